// File: rtl/dm_pkg.sv
// Shared encodings and sizing helpers for the byte-lane memory stage.
package dm_pkg;

    typedef enum logic [1:0] {
        MODE_WORD     = 2'b00,
        MODE_BYTE_U   = 2'b01,
        MODE_BYTE_S   = 2'b10,
        MODE_WORD_ALT = 2'b11
    } mode_e;

    function automatic int lane_count(input int data_w);
        return data_w / 8;
    endfunction

    // Number of byte-offset bits inside a word; zero for a single-lane word.
    function automatic int lane_bits(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 0;
    endfunction

    function automatic logic is_byte_mode(input logic [1:0] mode);
        return (mode == MODE_BYTE_U) || (mode == MODE_BYTE_S);
    endfunction

endpackage

// File: rtl/dm_ram.sv
// Single-port synchronous data RAM with per-byte-lane write enables.
// The read register only updates on a read; contents are never reset.
module dm_ram
    import dm_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int WORDS_W = 7
) (
    input  logic                  clk,
    input  logic                  rd_en_i,
    input  logic [DATA_W/8-1:0]   we_i,
    input  logic [WORDS_W-1:0]    addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);

    localparam int LANES = lane_count(DATA_W);

    logic [DATA_W-1:0] mem_q [2**WORDS_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (we_i[l]) begin
                mem_q[addr_i][l*8 +: 8] <= wdata_i[l*8 +: 8];
            end
        end
        if (rd_en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_stage_bytelane.sv
// Pipeline memory (DM) stage: word/byte loads and stores against a local RAM,
// misalignment detection with a sticky error flag, and saturating op counters.
module mem_stage_bytelane
    import dm_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int RW_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_ex,
    input  logic [DATA_W-1:0] ans_ex,
    input  logic [DATA_W-1:0] b_bypass,
    input  logic [RW_W-1:0]   rw_ex,
    input  logic              mem_en_ex,
    input  logic              mem_rw_ex,
    input  logic              mem_mux_sel_ex,
    input  logic [1:0]        mode_ex,
    input  logic              stall,
    input  logic              err_clr,
    output logic [DATA_W-1:0] mux_ans_dm,
    output logic [RW_W-1:0]   rw_dm,
    output logic              valid_dm,
    output logic              wb_en_dm,
    output logic              err_dm,
    output logic              err_flag,
    output logic [CNT_W-1:0]  load_cnt,
    output logic [CNT_W-1:0]  store_cnt
);

    localparam int LANES   = lane_count(DATA_W);
    localparam int LB      = lane_bits(LANES);
    localparam int OFF_W   = (LB > 0) ? LB : 1;
    localparam int WORDS_W = ADDR_W - LB;

    // ---------------- EX side: decode and RAM request ----------------
    logic              accept;
    logic              word_mode;
    logic [OFF_W-1:0]  off;
    logic              misaligned;
    logic              is_store;
    logic              do_store;
    logic              do_load;
    logic [WORDS_W-1:0] word_addr;
    logic [LANES-1:0]  lane_we;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Holding reset low also blocks RAM writes, so nothing lands while in reset.
    assign accept     = valid_ex & ~stall & reset;
    assign word_mode  = ~is_byte_mode(mode_ex);
    assign off        = ans_ex[OFF_W-1:0] & OFF_W'(LANES - 1);
    assign misaligned = mem_en_ex & word_mode & (off != '0);
    assign is_store   = mem_en_ex & mem_rw_ex;
    assign do_store   = accept & is_store & ~misaligned;
    assign do_load    = accept & mem_en_ex & ~mem_rw_ex & ~misaligned;
    assign word_addr  = ans_ex[ADDR_W-1:LB];
    assign wdata      = word_mode ? b_bypass : {LANES{b_bypass[7:0]}};

    always_comb begin
        lane_we = '0;
        if (do_store) begin
            if (word_mode) begin
                lane_we = '1;
            end else begin
                lane_we[off] = 1'b1;
            end
        end
    end

    dm_ram #(
        .DATA_W  (DATA_W),
        .WORDS_W (WORDS_W)
    ) u_ram (
        .clk     (clk),
        .rd_en_i (do_load),
        .we_i    (lane_we),
        .addr_i  (word_addr),
        .wdata_i (wdata),
        .rdata_o (ram_rdata)
    );

    // ---------------- EX -> DM stage registers ----------------
    logic              valid_q, valid_d;
    logic [RW_W-1:0]   rw_q, rw_d;
    logic              sel_q, sel_d;
    logic [DATA_W-1:0] ans_q, ans_d;
    logic [1:0]        mode_q, mode_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic              mis_q, mis_d;
    logic              store_q, store_d;
    logic              err_flag_q, err_flag_d;
    logic [CNT_W-1:0]  load_cnt_q, load_cnt_d;
    logic [CNT_W-1:0]  store_cnt_q, store_cnt_d;

    always_comb begin
        valid_d     = valid_q;
        rw_d        = rw_q;
        sel_d       = sel_q;
        ans_d       = ans_q;
        mode_d      = mode_q;
        off_d       = off_q;
        mis_d       = mis_q;
        store_d     = store_q;
        err_flag_d  = err_flag_q;
        load_cnt_d  = load_cnt_q;
        store_cnt_d = store_cnt_q;

        // An unstalled cycle without an instruction leaves a bubble behind.
        if (!stall) begin
            valid_d = valid_ex;
        end
        if (accept) begin
            rw_d    = rw_ex;
            sel_d   = mem_mux_sel_ex;
            ans_d   = ans_ex;
            mode_d  = mode_ex;
            off_d   = off;
            mis_d   = misaligned;
            store_d = is_store;
        end

        if (accept && misaligned) begin
            err_flag_d = 1'b1;
        end else if (err_clr) begin
            err_flag_d = 1'b0;
        end

        if (do_load && (load_cnt_q != '1)) begin
            load_cnt_d = load_cnt_q + 1'b1;
        end
        if (do_store && (store_cnt_q != '1)) begin
            store_cnt_d = store_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= 1'b0;
            rw_q        <= '0;
            sel_q       <= 1'b0;
            ans_q       <= '0;
            mode_q      <= '0;
            off_q       <= '0;
            mis_q       <= 1'b0;
            store_q     <= 1'b0;
            err_flag_q  <= 1'b0;
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            rw_q        <= rw_d;
            sel_q       <= sel_d;
            ans_q       <= ans_d;
            mode_q      <= mode_d;
            off_q       <= off_d;
            mis_q       <= mis_d;
            store_q     <= store_d;
            err_flag_q  <= err_flag_d;
            load_cnt_q  <= load_cnt_d;
            store_cnt_q <= store_cnt_d;
        end
    end

    // ---------------- DM side: lane extraction and result mux ----------------
    logic [7:0]        lane;
    logic signed [7:0] lane_s;

    assign lane   = ram_rdata[{off_q, 3'b000} +: 8];
    assign lane_s = lane;

    always_comb begin
        mux_ans_dm = ans_q;
        if (sel_q) begin
            case (mode_q)
                MODE_BYTE_U: mux_ans_dm = DATA_W'(lane);
                MODE_BYTE_S: mux_ans_dm = DATA_W'(lane_s);
                default:     mux_ans_dm = ram_rdata;
            endcase
        end
    end

    assign rw_dm     = rw_q;
    assign valid_dm  = valid_q;
    assign wb_en_dm  = valid_q & ~store_q & ~mis_q;
    assign err_dm    = valid_q & mis_q;
    assign err_flag  = err_flag_q;
    assign load_cnt  = load_cnt_q;
    assign store_cnt = store_cnt_q;

endmodule
